// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM bus arbiter: master IDs, grant-state encoding and SRAM size codes.
package sram_arb_pkg;

  localparam logic MST_INST = 1'b0;
  localparam logic MST_DATA = 1'b1;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order owner queue: remembers which master owns each accepted transaction until its response returns.
module sram_arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head_id
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [DEPTH-1:0] ids;

  // The extra wrap bit tells a full queue apart from an empty one when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_id = ids[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      ids[wr_ptr[PW-1:0]] <= push_id;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch (m0) and load/store (m1), routing responses in order.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise master 1 has fixed priority.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic [3:0]        m0_wstrb,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m0_wdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [ADDR_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic [3:0]        m1_wstrb,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [ADDR_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [ADDR_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [3:0]        s_wstrb,
  output logic [ADDR_W-1:0] s_addr,
  output logic [ADDR_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [ADDR_W-1:0] s_rdata
);

  arb_state_t state, state_next;
  logic       grant_q, grant_next;
  logic       winner;
  logic       winner_req;
  logic       handshake;
  logic       q_full, q_empty, head_id;
`ifdef SRAM_ARB_RR_EN
  logic       last_win;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      grant_q <= MST_INST;
`ifdef SRAM_ARB_RR_EN
      last_win <= MST_DATA;
`endif
    end else begin
      state   <= state_next;
      grant_q <= grant_next;
`ifdef SRAM_ARB_RR_EN
      if (handshake) last_win <= winner;
`endif
    end
  end

  // A stalled request keeps its grant so the downstream never sees the address change under it.
  always_comb begin
    state_next = state;
    grant_next = grant_q;
    winner     = MST_INST;
    if (state == ARB_LOCKED) begin
      winner = grant_q;
    end else if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
      winner = ~last_win;
`else
      winner = MST_DATA;
`endif
    end else if (m1_req) begin
      winner = MST_DATA;
    end

    winner_req = (winner == MST_DATA) ? m1_req : m0_req;
    s_req      = winner_req && !q_full && !reset;
    handshake  = s_req && s_addr_ok;

    if (state == ARB_IDLE) begin
      if (s_req && !s_addr_ok) begin
        state_next = ARB_LOCKED;
        grant_next = winner;
      end
    end else if (handshake) begin
      state_next = ARB_IDLE;
    end

    s_wr    = (winner == MST_DATA) ? m1_wr    : m0_wr;
    s_size  = (winner == MST_DATA) ? m1_size  : m0_size;
    s_wstrb = (winner == MST_DATA) ? m1_wstrb : m0_wstrb;
    s_addr  = (winner == MST_DATA) ? m1_addr  : m0_addr;
    s_wdata = (winner == MST_DATA) ? m1_wdata : m0_wdata;

    m0_addr_ok = handshake && (winner == MST_INST);
    m1_addr_ok = handshake && (winner == MST_DATA);
    m0_data_ok = s_data_ok && !q_empty && !reset && (head_id == MST_INST);
    m1_data_ok = s_data_ok && !q_empty && !reset && (head_id == MST_DATA);
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
  end

  sram_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (handshake),
    .push_id (winner),
    .pop     (s_data_ok),
    .full    (q_full),
    .empty   (q_empty),
    .head_id (head_id)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(s_data_ok && q_empty))
        else $error("s_data_ok with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: directed requests, a latency-2 downstream model and an in-order monitor.
module tb_sram_bus_arbiter;
  import sram_arb_pkg::*;

  localparam logic [31:0] RD_OFS = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m0_addr_ok, m0_data_ok;
  logic [1:0]  m0_size;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_addr_ok, m1_data_ok;
  logic [1:0]  m1_size;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;

  sram_bus_arbiter #(
    .MAX_OUTSTANDING (4),
    .ADDR_W          (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_wr      (m0_wr),
    .m0_size    (m0_size),
    .m0_wstrb   (m0_wstrb),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_addr_ok (m0_addr_ok),
    .m0_data_ok (m0_data_ok),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_wr      (m1_wr),
    .m1_size    (m1_size),
    .m1_wstrb   (m1_wstrb),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_addr_ok (m1_addr_ok),
    .m1_data_ok (m1_data_ok),
    .m1_rdata   (m1_rdata),
    .s_req      (s_req),
    .s_wr       (s_wr),
    .s_size     (s_size),
    .s_wstrb    (s_wstrb),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_addr_ok  (s_addr_ok),
    .s_data_ok  (s_data_ok),
    .s_rdata    (s_rdata)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [72:0] exp_addr_q[$];
  logic [65:0] exp_resp_q[$];
  int          pend_due[$];
  logic [31:0] pend_data[$];
  int          cyc        = 0;
  logic        slave_hold = 1'b0;

  task automatic checkOutput(input string name, input logic [72:0] act, input logic [72:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected forwarded address-phase fields, mirroring how applyStimulus builds each master's fields.
  function automatic logic [72:0] addr_exp(input logic mst, input logic [31:0] a);
    if (mst == MST_DATA)
      return {2'b10, a[2], SZ_HALF, (a[2] ? 4'hF : 4'h0), a, a ^ 32'hAAAA_0000};
    return {2'b01, 1'b0, SZ_WORD, 4'h0, a, a ^ 32'h5555_5555};
  endfunction

  function automatic logic [65:0] resp_exp(input logic mst, input logic [31:0] a);
    logic [31:0] rd;
    rd = a + RD_OFS;
    return {((mst == MST_DATA) ? 2'b10 : 2'b01), rd, rd};
  endfunction

  task automatic expect_txn(input logic mst, input logic [31:0] a, input bit with_resp);
    exp_addr_q.push_back(addr_exp(mst, a));
    if (with_resp) exp_resp_q.push_back(resp_exp(mst, a));
  endtask

  // One clock cycle of master-side stimulus; returns just after the negative edge.
  task automatic applyStimulus(input logic rst, input logic r0, input logic [31:0] a0,
                               input logic r1, input logic [31:0] a1, input logic aok);
    @(posedge clk);
    #1;
    reset     = rst;
    m0_req    = r0;
    m0_wr     = 1'b0;
    m0_size   = SZ_WORD;
    m0_wstrb  = 4'h0;
    m0_addr   = a0;
    m0_wdata  = a0 ^ 32'h5555_5555;
    m1_req    = r1;
    m1_wr     = a1[2];
    m1_size   = SZ_HALF;
    m1_wstrb  = a1[2] ? 4'hF : 4'h0;
    m1_addr   = a1;
    m1_wdata  = a1 ^ 32'hAAAA_0000;
    s_addr_ok = aok;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic check_all_zero(input string name);
    checkOutput(name, {68'b0, s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, 73'b0);
  endtask

  // Downstream model: every accepted address returns data two cycles later, in order, unless held.
  always @(negedge clk) begin
    if (!reset && s_req && s_addr_ok) begin
      pend_due.push_back(cyc + 2);
      pend_data.push_back(s_addr + RD_OFS);
    end
  end

  initial begin
    s_data_ok = 1'b0;
    s_rdata   = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (reset) begin
        pend_due.delete();
        pend_data.delete();
        s_data_ok = 1'b0;
      end else if (!slave_hold && pend_due.size() > 0 && pend_due[0] <= cyc) begin
        s_data_ok = 1'b1;
        s_rdata   = pend_data.pop_front();
        void'(pend_due.pop_front());
      end else begin
        s_data_ok = 1'b0;
        s_rdata   = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: every addr_ok / data_ok the DUT presents must match the head of its scoreboard queue.
  initial begin
    logic [72:0] act_a;
    logic [65:0] act_d;
    forever begin
      @(negedge clk);
      act_a = {m1_addr_ok, m0_addr_ok, s_wr, s_size, s_wstrb, s_addr, s_wdata};
      act_d = {m1_data_ok, m0_data_ok, m0_rdata, m1_rdata};
      if (m0_addr_ok || m1_addr_ok) begin
        if (exp_addr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL addr_unexpected: got %h expected none", act_a);
        end else begin
          checkOutput("addr_phase", act_a, exp_addr_q.pop_front());
        end
      end
      if (m0_data_ok || m1_data_ok) begin
        if (exp_resp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL resp_unexpected: got %h expected none", act_d);
        end else begin
          checkOutput("resp_phase", {7'b0, act_d}, {7'b0, exp_resp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    {m0_req, m0_wr, m0_size, m0_wstrb, m0_addr, m0_wdata} = '0;
    {m1_req, m1_wr, m1_size, m1_wstrb, m1_addr, m1_wdata} = '0;
    s_addr_ok = 1'b0;

    $display("[TB] reset with both masters requesting");
    applyStimulus(1'b1, 1'b1, 32'h10, 1'b1, 32'h14, 1'b1);
    check_all_zero("reset_outputs_c0");
    applyStimulus(1'b1, 1'b1, 32'h10, 1'b1, 32'h14, 1'b1);
    check_all_zero("reset_outputs_c1");

    $display("[TB] address conflict");
`ifdef SRAM_ARB_RR_EN
    expect_txn(MST_INST, 32'h100, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 32'h204, 1'b1);
    expect_txn(MST_DATA, 32'h204, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h204, 1'b1);
`else
    expect_txn(MST_DATA, 32'h204, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 32'h204, 1'b1);
    expect_txn(MST_INST, 32'h100, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
`endif
    idle(4);

    $display("[TB] grant lock");
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    checkOutput("lock_c1_s_addr", {40'b0, s_req, s_addr}, {40'b0, 1'b1, 32'h300});
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 32'h404, 1'b0);
    checkOutput("lock_c2_s_addr", {40'b0, s_req, s_addr}, {40'b0, 1'b1, 32'h300});
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 32'h404, 1'b0);
    checkOutput("lock_c3_s_addr", {40'b0, s_req, s_addr}, {40'b0, 1'b1, 32'h300});
    expect_txn(MST_INST, 32'h300, 1'b1);
    expect_txn(MST_DATA, 32'h404, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 32'h404, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h404, 1'b1);
    idle(4);

    $display("[TB] queue full");
    slave_hold = 1'b1;
    expect_txn(MST_INST, 32'h0234_5678, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0234_5678, 1'b0, 32'h0, 1'b1);
    expect_txn(MST_INST, 32'h600, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1);
    expect_txn(MST_INST, 32'h604, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h604, 1'b0, 32'h0, 1'b1);
    expect_txn(MST_INST, 32'h608, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h608, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1);
    checkOutput("full_blocks_c0", {72'b0, s_req}, 73'b0);
    applyStimulus(1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1);
    checkOutput("full_blocks_c1", {72'b0, s_req}, 73'b0);
    slave_hold = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1);
    checkOutput("full_blocks_during_pop", {72'b0, s_req}, 73'b0);
    slave_hold = 1'b1;
    expect_txn(MST_INST, 32'h700, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1);
    slave_hold = 1'b0;
    idle(7);

    $display("[TB] pointer wrap with overlapping push/pop");
    for (int i = 0; i < 10; i++) begin
      logic        mst;
      logic [31:0] a;
      mst = (i % 2 == 1) ? MST_DATA : MST_INST;
      a   = 32'h900 + 32'(16 * i);
      expect_txn(mst, a, 1'b1);
      if (mst == MST_DATA) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, a, 1'b1);
      else                 applyStimulus(1'b0, 1'b1, a, 1'b0, 32'h0, 1'b1);
    end
    idle(5);

    $display("[TB] reset mid-flight");
    slave_hold = 1'b1;
    expect_txn(MST_DATA, 32'hA00, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hA00, 1'b1);
    expect_txn(MST_DATA, 32'hA04, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hA04, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'hA08, 1'b1, 32'hA0C, 1'b1);
    check_all_zero("reset_midflight_outputs");
    slave_hold = 1'b0;
    expect_txn(MST_INST, 32'hA08, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'hA08, 1'b0, 32'h0, 1'b1);
    idle(5);

`ifdef SRAM_ARB_RR_EN
    $display("[TB] round-robin alternation");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a0, a1;
      a0 = 32'hB00 + 32'(16 * ((k + 1) / 2));
      a1 = 32'hC00 + 32'(16 * (k / 2));
      if (k % 2 == 1) expect_txn(MST_DATA, a1, 1'b1);
      else            expect_txn(MST_INST, a0, 1'b1);
      applyStimulus(1'b0, 1'b1, a0, 1'b1, a1, 1'b1);
    end
    idle(5);
`endif

    checkOutput("addr_queue_drained", {41'b0, 32'(exp_addr_q.size())}, 73'b0);
    checkOutput("resp_queue_drained", {41'b0, 32'(exp_resp_q.size())}, 73'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
